// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor sequencer: one shared 1-bit slice (two half adders
// plus carry OR) processes WIDTH-bit operands LSB-first, one bit per clock.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             sub_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ack_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [CW-1:0]    r_bitcnt;

  logic             w_h1;
  logic             w_g1;
  logic             w_s;
  logic             w_g2;
  logic             w_carry_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_h1        = r_opa[0] ^ r_opb[0];
  assign w_g1        = r_opa[0] & r_opb[0];
  assign w_s         = w_h1 ^ r_carry;
  assign w_g2        = w_h1 & r_carry;
  assign w_carry_nxt = w_g1 | w_g2;
  assign w_last      = (r_bitcnt == CW'(WIDTH - 1));

  // Sum bits shift in behind the consumed opA bits, so opA doubles as the result register.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_nxt = w_s;
    end else begin : g_res_wn
      assign w_res_nxt = {w_s, r_opa[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_opa     <= '0;
      r_opb     <= '0;
      r_carry   <= 1'b0;
      r_bitcnt  <= '0;
      ready_out <= 1'b1;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      c_out     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_opa     <= a_in;
            r_opb     <= b_in ^ {WIDTH{sub_in}};
            r_carry   <= sub_in;
            r_bitcnt  <= '0;
            r_state   <= S_RUN;
            ready_out <= 1'b0;
            busy_out  <= 1'b1;
          end
        end
        S_RUN: begin
          r_opa    <= w_res_nxt;
          r_opb    <= r_opb >> 1;
          r_carry  <= w_carry_nxt;
          r_bitcnt <= r_bitcnt + CW'(1);
          if (w_last) begin
            sum_out  <= w_res_nxt;
            c_out    <= w_carry_nxt;
            r_state  <= S_DONE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end
        end
        S_DONE: begin
          if (ack_in) begin
            r_state   <= S_IDLE;
            done_out  <= 1'b0;
            ready_out <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          ready_out <= 1'b1;
          busy_out  <= 1'b0;
          done_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes expected {c,sum}, monitor
// pops and compares on each rising done_out.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk_in   = 1'b0;
  logic         rst_in   = 1'b0;
  logic         start_in = 1'b0;
  logic         sub_in   = 1'b0;
  logic         ack_in   = 1'b0;
  logic [W-1:0] a_in     = '0;
  logic [W-1:0] b_in     = '0;
  logic         ready_out, busy_out, done_out, c_out;
  logic [W-1:0] sum_out;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [W:0] exp_q[$];
  logic       prev_done = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .sub_in(sub_in),
    .a_in(a_in), .b_in(b_in), .ack_in(ack_in), .ready_out(ready_out),
    .busy_out(busy_out), .done_out(done_out), .sum_out(sum_out), .c_out(c_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each newly presented result against the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_done = 1'b0;
    end else begin
      if (done_out && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {23'd0, c_out, sum_out}, 32'hFFFF_FFFF);
        end else begin
          check("result", {23'd0, c_out, sum_out}, {23'd0, exp_q.pop_front()});
        end
      end
      prev_done = done_out;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready_out && t < 100) begin
      @(posedge clk_in); #1;
      t++;
    end
    check("ready_wait", {31'd0, ready_out}, 32'd1);
  endtask

  // pulse=1 keeps start_in high through RUN, DONE and the ack edge (must be ignored).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int ack_dly, input logic pulse, input logic [W:0] exp);
    int n = 0;
    wait_ready();
    a_in = a; b_in = b; sub_in = sub; start_in = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk_in); #1;
    start_in = pulse;
    a_in = ~a; b_in = a ^ b; sub_in = ~sub;
    check("busy_after_accept", {29'd0, ready_out, busy_out, done_out}, 32'b010);
    while (!done_out && n < W + 5) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("latency", n, W);
    for (int k = 0; k < ack_dly; k++) begin
      @(posedge clk_in); #1;
      check("done_held", {31'd0, done_out}, 32'd1);
    end
    ack_in = 1'b1;
    @(posedge clk_in); #1;
    ack_in = 1'b0;
    start_in = 1'b0;
    check("ready_after_ack", {29'd0, ready_out, busy_out, done_out}, 32'b100);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    else     return {1'b0, a} + {1'b0, b};
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    #1 rst_in = 1'b1;
    #2;
    check("reset_outputs", {21'd0, ready_out, busy_out, done_out, c_out, sum_out}, 32'h800);
    @(negedge clk_in);
    @(negedge clk_in) rst_in = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0, 9'h010);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 9'h100);
    run_op(8'h00, 8'h00, 1'b0, 1, 1'b0, 9'h000);
    run_op(8'h07, 8'h05, 1'b1, 0, 1'b0, 9'h102);
    run_op(8'h05, 8'h07, 1'b1, 2, 1'b0, 9'h0FE);
    // Start held through RUN/DONE with changed operands, ack withheld 5 cycles.
    run_op(8'hA5, 8'h3C, 1'b0, 5, 1'b1, 9'h0E1);
    for (int k = 0; k < 3; k++) begin
      ack_in = 1'b1;
      @(posedge clk_in); #1;
      check("idle_no_op", {29'd0, ready_out, busy_out, done_out}, 32'b100);
    end
    ack_in = 1'b0;

    // Asynchronous reset while bit 3 is in flight.
    wait_ready();
    a_in = 8'h11; b_in = 8'h22; sub_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("async_reset", {21'd0, ready_out, busy_out, done_out, c_out, sum_out}, 32'h800);
    @(negedge clk_in) rst_in = 1'b0;
    run_op(8'h3C, 8'h0A, 1'b0, 0, 1'b0, 9'h046);

    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, int'($urandom_range(0, 3)), 1'b0, model(ra, rb, rs));
    end

    repeat (2) @(posedge clk_in);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
